// File: rtl/mul_pipe.sv
// mul_pipe: pipelined (WIDTH+1)x(WIDTH+1) signed multiplier for RV32M.
//
// Implements MUL / MULH / MULHSU / MULHU at one op per cycle. Operands are
// extended to WIDTH+1 bits according to the op, expanded into sign-extended
// partial products, reduced by a 3:2 carry-save tree and resolved by a final
// carry-propagate add. Pipeline ranks:
//   rank 0           : registered raw operands, op and tag
//   rank 1           : registered carry-save sum/carry pair (STAGES >= 2)
//   ranks 2..STAGES-1: registered selected result (STAGES >= 3)
// With STAGES=1 the tree and CPA sit combinationally after rank 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      kill every in-flight op (and any op presented) this cycle
//   in_valid   op presented            in_ready   block can accept this cycle
//   in_op      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_a/in_b  rs1 / rs2 operands      in_tag     destination tag
//   out_valid  result presented        out_ready  consumer accepts result
//   out_result selected product half   out_tag    tag of presented result

module mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW   = 2 * WIDTH;   // kept product width
    localparam int ROWS = WIDTH + 2;   // partial products + negation correction

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b11;

    // ------------------------------------------------------------------
    // Datapath functions
    // ------------------------------------------------------------------

    // Signed (WIDTH+1)x(WIDTH+1) product, kept modulo 2^PW, returned as a
    // redundant {sum, carry} pair. The top partial product (weight of the
    // sign bit of b) is negative: it is added as its one's complement plus
    // a separate '1' correction row.
    function automatic logic [2*PW-1:0] csa_tree(input logic [WIDTH:0] a_ext,
                                                 input logic [WIDTH:0] b_ext);
        logic [PW-1:0] row [ROWS];
        logic [PW-1:0] a_w;
        logic [PW-1:0] x, y, z;
        int            n;
        int            ng;
        a_w = {{(WIDTH-1){a_ext[WIDTH]}}, a_ext};
        for (int i = 0; i < WIDTH; i++)
            row[i] = b_ext[i] ? (a_w << i) : '0;
        row[WIDTH]   = b_ext[WIDTH] ? ~(a_w << WIDTH) : '0;
        row[WIDTH+1] = PW'(b_ext[WIDTH]);
        // Each level turns every full group of three rows into two; rows
        // left over are passed through. In-place update is safe because a
        // group's outputs land at indices no later group still reads.
        n = ROWS;
        for (int lvl = 0; lvl < ROWS; lvl++) begin
            if (n > 2) begin
                ng = n / 3;
                for (int g = 0; g < ROWS / 3; g++) begin
                    if (g < ng) begin
                        x = row[3*g];
                        y = row[3*g+1];
                        z = row[3*g+2];
                        row[2*g]   = x ^ y ^ z;
                        row[2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    if (3*ng + k < n)
                        row[2*ng+k] = row[3*ng+k];
                end
                n = n - ng;
            end
        end
        return {row[0], row[1]};
    endfunction

    function automatic logic [WIDTH-1:0] select_half(input logic [1:0]    op,
                                                     input logic [PW-1:0] p);
        return (op == OP_MUL) ? p[WIDTH-1:0] : p[PW-1:WIDTH];
    endfunction

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic [STAGES-1:0] valid_q;
    logic              stall;

    assign out_valid = valid_q[STAGES-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    // NOTE: sequential state uses non-blocking assignments so every rank
    // samples the previous rank's value from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (!stall) begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < STAGES; i++)
                valid_q[i] <= valid_q[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Rank 0: raw operands
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r0_a, r0_b;
    logic [1:0]       r0_op;
    logic [TAG_W-1:0] r0_tag;

    // NOTE: datapath registers carry no reset; their contents only matter
    // while the matching valid bit is set, and outputs are gated below.
    always_ff @(posedge clk) begin
        if (!stall) begin
            r0_a   <= in_a;
            r0_b   <= in_b;
            r0_op  <= in_op;
            r0_tag <= in_tag;
        end
    end

    // a is unsigned only for MULHU; b is unsigned for MULHSU and MULHU.
    logic [WIDTH:0]     a_ext, b_ext;
    logic [2*PW-1:0]    tree_out;

    assign a_ext    = {(r0_op != OP_MULHU) & r0_a[WIDTH-1], r0_a};
    assign b_ext    = {~r0_op[1] & r0_b[WIDTH-1], r0_b};
    assign tree_out = csa_tree(a_ext, b_ext);

    logic [WIDTH-1:0] last_result;
    logic [TAG_W-1:0] last_tag;

    // ------------------------------------------------------------------
    // Remaining ranks
    // ------------------------------------------------------------------
    generate
        if (STAGES == 1) begin : g_one
            logic [PW-1:0] product;
            assign product     = tree_out[2*PW-1:PW] + tree_out[PW-1:0];
            assign last_result = select_half(r0_op, product);
            assign last_tag    = r0_tag;
        end else begin : g_multi
            logic [PW-1:0]    r1_sum, r1_carry, product;
            logic [1:0]       r1_op;
            logic [TAG_W-1:0] r1_tag;
            logic [WIDTH-1:0] cpa_result;

            always_ff @(posedge clk) begin
                if (!stall) begin
                    r1_sum   <= tree_out[2*PW-1:PW];
                    r1_carry <= tree_out[PW-1:0];
                    r1_op    <= r0_op;
                    r1_tag   <= r0_tag;
                end
            end

            assign product    = r1_sum + r1_carry;
            assign cpa_result = select_half(r1_op, product);

            if (STAGES == 2) begin : g_two
                assign last_result = cpa_result;
                assign last_tag    = r1_tag;
            end else begin : g_deep
                // Extra ranks follow the CPA so retiming can pull them back
                // into the adder and tree.
                logic [WIDTH-1:0] res_q [STAGES-2];
                logic [TAG_W-1:0] tag_q [STAGES-2];

                always_ff @(posedge clk) begin
                    if (!stall) begin
                        res_q[0] <= cpa_result;
                        tag_q[0] <= r1_tag;
                        for (int i = 1; i < STAGES - 2; i++) begin
                            res_q[i] <= res_q[i-1];
                            tag_q[i] <= tag_q[i-1];
                        end
                    end
                end

                assign last_result = res_q[STAGES-3];
                assign last_tag    = tag_q[STAGES-3];
            end
        end
    endgenerate

    // Gate the unreset datapath so idle outputs read zero.
    assign out_result = out_valid ? last_result : '0;
    assign out_tag    = out_valid ? last_tag    : '0;

endmodule
